// File: rtl/clk_div_ctrl_pkg.sv
// Shared state encoding and default sizing for the divider configuration controller.
package clk_div_ctrl_pkg;

  localparam int RATIO_W_DEF    = 8;
  localparam int RST_RATIO_DEF  = 32;
  localparam int SETTLE_CYC_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  // What the current DRAIN/SETTLE pass is doing: a ratio change or a gate transition.
  typedef enum logic [1:0] {
    OP_REQ      = 2'd0,
    OP_GATE_OFF = 2'd1,
    OP_GATE_ON  = 2'd2
  } op_t;

endpackage

// File: rtl/clk_div_cfg_ctrl_rr_arb2.sv
// Two-input round-robin arbiter; the pointer moves past the winner whenever a grant is taken.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       adv,
  output logic       gnt_vld,
  output logic       gnt_id
);

  logic ptr_reg;
  logic ptr_next;

  assign gnt_vld = |req;
  // On contention the pointer decides; otherwise the sole requester wins.
  assign gnt_id  = (req[0] & req[1]) ? ptr_reg : req[1];

  always_comb begin
    ptr_next = ptr_reg;
    if (adv && gnt_vld) begin
      ptr_next = ~gnt_id;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_reg <= 1'b0;
    end else begin
      ptr_reg <= ptr_next;
    end
  end

endmodule

// File: rtl/clk_div_cfg_ctrl.sv
// Divider ratio/enable controller: drains the current period, loads a new ratio, settles, then acks.
module clk_div_cfg_ctrl
  import clk_div_ctrl_pkg::*;
#(
  parameter int RATIO_W    = RATIO_W_DEF,
  parameter int RST_RATIO  = RST_RATIO_DEF,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
  input  logic               i_clk_ref,
  input  logic               i_rst_n,
  input  logic [1:0]         i_req,
  input  logic [RATIO_W-1:0] i_ratio0,
  input  logic [RATIO_W-1:0] i_ratio1,
  input  logic               i_gate,
  output logic               o_div_en,
  output logic [RATIO_W-1:0] o_div_ratio,
  output logic [1:0]         o_ack,
  output logic [1:0]         o_nack,
  output logic               o_busy
);

  localparam logic [RATIO_W-1:0] SETTLE_INIT = RATIO_W'(SETTLE_CYC - 1);
  localparam logic [RATIO_W-1:0] ONE         = RATIO_W'(1);

  state_t             state_reg, state_next;
  op_t                op_reg, op_next;
  logic               div_en_reg, div_en_next;
  logic [RATIO_W-1:0] div_ratio_reg, div_ratio_next;
  logic [RATIO_W-1:0] cnt_reg, cnt_next;
  logic [RATIO_W-1:0] cap_ratio_reg, cap_ratio_next;
  logic               gid_reg, gid_next;
  logic [1:0]         ack_reg, ack_next;
  logic [1:0]         nack_reg, nack_next;
  logic               busy_reg;

  logic [1:0]         req_eff;
  logic               gnt_vld, gnt_id;
  logic [RATIO_W-1:0] gnt_ratio;
  logic               is_idle, gate_off_go, gate_on_go, grant_take;
  logic               ratio_zero, ratio_same, cnt_zero;
  logic               imm_nack, imm_ack, done_ack;

  // A requester whose response is on the wire this cycle is still holding req; mask it.
  assign req_eff     = i_req & ~(ack_reg | nack_reg);
  assign gnt_ratio   = gnt_id ? i_ratio1 : i_ratio0;
  assign is_idle     = (state_reg == ST_IDLE);
  assign gate_off_go = is_idle &  i_gate &  div_en_reg;
  assign gate_on_go  = is_idle & ~i_gate & ~div_en_reg;
  assign grant_take  = is_idle & ~gate_off_go & ~gate_on_go & gnt_vld;
  assign ratio_zero  = (gnt_ratio == '0);
  assign ratio_same  = (gnt_ratio == div_ratio_reg) && (div_en_reg == ~i_gate);
  assign cnt_zero    = (cnt_reg == '0);
  assign imm_nack    = grant_take & ratio_zero;
  assign imm_ack     = grant_take & ~ratio_zero & ratio_same;
  assign done_ack    = (state_reg == ST_SETTLE) & cnt_zero & (op_reg == OP_REQ);

  rr_arb2 u_arb (
    .clk     (i_clk_ref),
    .rst_n   (i_rst_n),
    .req     (req_eff),
    .adv     (grant_take),
    .gnt_vld (gnt_vld),
    .gnt_id  (gnt_id)
  );

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_resp
      assign ack_next[gi]  = (imm_ack & (gnt_id == 1'(gi))) | (done_ack & (gid_reg == 1'(gi)));
      assign nack_next[gi] = imm_nack & (gnt_id == 1'(gi));
    end
  endgenerate

  always_ff @(posedge i_clk_ref) begin
    if (!i_rst_n) begin
      state_reg     <= ST_IDLE;
      op_reg        <= OP_REQ;
      div_en_reg    <= 1'b1;
      div_ratio_reg <= RATIO_W'(RST_RATIO);
      cnt_reg       <= '0;
      cap_ratio_reg <= '0;
      gid_reg       <= 1'b0;
      ack_reg       <= '0;
      nack_reg      <= '0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      op_reg        <= op_next;
      div_en_reg    <= div_en_next;
      div_ratio_reg <= div_ratio_next;
      cnt_reg       <= cnt_next;
      cap_ratio_reg <= cap_ratio_next;
      gid_reg       <= gid_next;
      ack_reg       <= ack_next;
      nack_reg      <= nack_next;
      busy_reg      <= (state_next != ST_IDLE);
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (gate_off_go) begin
          state_next = ST_DRAIN;
        end else if (gate_on_go) begin
          state_next = ST_SETTLE;
        end else if (grant_take && !ratio_zero && !ratio_same) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (cnt_zero) begin
          state_next = (op_reg == OP_GATE_OFF) ? ST_IDLE : ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_zero) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    op_next        = op_reg;
    div_en_next    = div_en_reg;
    div_ratio_next = div_ratio_reg;
    cnt_next       = cnt_reg;
    cap_ratio_next = cap_ratio_reg;
    gid_next       = gid_reg;
    case (state_reg)
      ST_IDLE: begin
        if (gate_off_go) begin
          // Let the running period finish before stopping the divider.
          op_next  = OP_GATE_OFF;
          cnt_next = div_ratio_reg - ONE;
        end else if (gate_on_go) begin
          op_next  = OP_GATE_ON;
          cnt_next = SETTLE_INIT;
        end else if (grant_take) begin
          gid_next       = gnt_id;
          cap_ratio_next = gnt_ratio;
          if (!ratio_zero && !ratio_same) begin
            op_next     = OP_REQ;
            div_en_next = 1'b0;
            cnt_next    = div_ratio_reg - ONE;
          end
        end
      end
      ST_DRAIN: begin
        if (!cnt_zero) begin
          cnt_next = cnt_reg - ONE;
        end else if (op_reg == OP_GATE_OFF) begin
          div_en_next = 1'b0;
        end else begin
          div_ratio_next = cap_ratio_reg;
          cnt_next       = SETTLE_INIT;
        end
      end
      ST_SETTLE: begin
        if (!cnt_zero) begin
          cnt_next = cnt_reg - ONE;
        end else begin
          div_en_next = ~i_gate;
        end
      end
      default: ;
    endcase
  end

  assign o_div_en    = div_en_reg;
  assign o_div_ratio = div_ratio_reg;
  assign o_ack       = ack_reg;
  assign o_nack      = nack_reg;
  assign o_busy      = busy_reg;

endmodule
